// File: rtl/motion_box_overlay_pkg.sv
// Shared image_process types: RGB pixel struct, fixed colours and width helpers
// used by the motion box overlay and its tracker.
package image_process_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t COLOR_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
   localparam rgb_t COLOR_RED   = '{r: 8'hFF, g: 8'h00, b: 8'h00};

   // Width of a coordinate that counts 0..n-1 (never narrower than 1 bit)
   function automatic int coord_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int count_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/motion_box_overlay_if.sv
// Pixel-in / overlay-out bundle of the motion box overlay; the source side uses
// master, the overlay block uses slave.
interface motion_box_overlay_if
   import image_process_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int DW    = 10,
   parameter int GW    = 8
);
   localparam int XW = coord_w(IMG_W);
   localparam int YW = coord_w(IMG_H);
   localparam int CW = count_w(IMG_W * IMG_H);

   logic          in_valid;
   logic          in_sof;
   logic [DW-1:0] cur_value;
   logic [DW-1:0] bg_value;
   logic [GW-1:0] gray;
   logic [DW-1:0] threshold;
   logic [CW-1:0] min_count;
   rgb_t          box_color;

   logic          out_valid;
   logic          out_sof;
   rgb_t          out_rgb;
   logic          box_valid;
   logic [XW-1:0] box_x1;
   logic [XW-1:0] box_x2;
   logic [YW-1:0] box_y1;
   logic [YW-1:0] box_y2;
   logic [CW-1:0] motion_count;
   logic          frame_done;

   modport master (
      output in_valid, in_sof, cur_value, bg_value, gray, threshold, min_count, box_color,
      input  out_valid, out_sof, out_rgb, box_valid, box_x1, box_x2, box_y1, box_y2,
             motion_count, frame_done
   );

   modport slave (
      input  in_valid, in_sof, cur_value, bg_value, gray, threshold, min_count, box_color,
      output out_valid, out_sof, out_rgb, box_valid, box_x1, box_x2, box_y1, box_y2,
             motion_count, frame_done
   );
endinterface

// File: rtl/motion_box_overlay_tracker.sv
// Per-frame motion bounding box and motion count; latches box/count/valid and
// pulses frame_done after the last pixel of a frame, sof discards a partial frame.
module motion_box_tracker
   import image_process_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int MARGIN = 5,
   localparam int XW = coord_w(IMG_W),
   localparam int YW = coord_w(IMG_H),
   localparam int CW = count_w(IMG_W * IMG_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic          i_sof,
   input  logic [XW-1:0] i_x,
   input  logic [YW-1:0] i_y,
   input  logic          i_motion,
   input  logic [CW-1:0] i_min_count,
   output logic          o_box_valid,
   output logic [XW-1:0] o_box_x1,
   output logic [XW-1:0] o_box_x2,
   output logic [YW-1:0] o_box_y1,
   output logic [YW-1:0] o_box_y2,
   output logic [CW-1:0] o_motion_count,
   output logic          o_frame_done
);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic [XW-1:0] r_x1, r_x2, w_x1, w_x2;
   logic [YW-1:0] r_y1, r_y2, w_y1, w_y2;
   logic [CW-1:0] r_cnt, w_cnt;
   logic          w_in_margin, w_last;

   assign w_in_margin = (int'(i_x) >= MARGIN) && (int'(i_x) < IMG_W - MARGIN) &&
                        (int'(i_y) >= MARGIN) && (int'(i_y) < IMG_H - MARGIN);
   assign w_last      = (i_x == X_LAST) && (i_y == Y_LAST);

   // Working box after this pixel; a sof pixel starts from the empty box
   always_comb begin
      w_x1  = i_sof ? X_LAST : r_x1;
      w_x2  = i_sof ? '0     : r_x2;
      w_y1  = i_sof ? Y_LAST : r_y1;
      w_y2  = i_sof ? '0     : r_y2;
      w_cnt = i_sof ? '0     : r_cnt;
      if (i_motion && w_in_margin) begin
         if (i_x < w_x1) w_x1 = i_x;
         if (i_x > w_x2) w_x2 = i_x;
         if (i_y < w_y1) w_y1 = i_y;
         if (i_y > w_y2) w_y2 = i_y;
      end
      if (i_motion && (w_cnt != '1)) w_cnt = w_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x1           <= X_LAST;
         r_x2           <= '0;
         r_y1           <= Y_LAST;
         r_y2           <= '0;
         r_cnt          <= '0;
         o_box_valid    <= 1'b0;
         o_box_x1       <= '0;
         o_box_x2       <= '0;
         o_box_y1       <= '0;
         o_box_y2       <= '0;
         o_motion_count <= '0;
         o_frame_done   <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         if (i_valid) begin
            if (w_last) begin
               o_box_x1       <= w_x1;
               o_box_x2       <= w_x2;
               o_box_y1       <= w_y1;
               o_box_y2       <= w_y2;
               o_motion_count <= w_cnt;
               o_box_valid    <= (w_cnt >= i_min_count);
               o_frame_done   <= 1'b1;
               r_x1           <= X_LAST;
               r_x2           <= '0;
               r_y1           <= Y_LAST;
               r_y2           <= '0;
               r_cnt          <= '0;
            end else begin
               r_x1  <= w_x1;
               r_x2  <= w_x2;
               r_y1  <= w_y1;
               r_y2  <= w_y2;
               r_cnt <= w_cnt;
            end
         end
      end
   end

endmodule

// File: rtl/motion_box_overlay.sv
// Three-stage motion threshold + box overlay pipeline. Optional red highlight of
// motion pixels is enabled by defining MOTION_HIGHLIGHT_EN.
module motion_box_overlay
   import image_process_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int DW     = 10,
   parameter int GW     = 8,
   parameter int MARGIN = 5,
   parameter int BORDER = 10,
   localparam int XW = coord_w(IMG_W),
   localparam int YW = coord_w(IMG_H),
   localparam int CW = count_w(IMG_W * IMG_H)
) (
   input logic clk,
   input logic rst,
   motion_box_overlay_if.slave bus
);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic [XW-1:0] r_x, w_px;
   logic [YW-1:0] r_y, w_py;

   logic          r_s1_valid, r_s1_sof;
   logic [XW-1:0] r_s1_x;
   logic [YW-1:0] r_s1_y;
   logic [DW-1:0] r_s1_cur, r_s1_bg, r_s1_thr;
   logic [GW-1:0] r_s1_gray;
   logic [CW-1:0] r_s1_minc;
   rgb_t          r_s1_color;

   logic          r_s2_valid, r_s2_sof, r_s2_motion;
   logic [XW-1:0] r_s2_x;
   logic [YW-1:0] r_s2_y;
   logic [GW-1:0] r_s2_gray;
   logic [CW-1:0] r_s2_minc;
   rgb_t          r_s2_color;

   logic          r_out_valid, r_out_sof;
   rgb_t          r_out_rgb;

   logic [DW-1:0] w_abs;
   logic [7:0]    w_gray8;
   logic          w_border, w_on_outline;
   rgb_t          w_rgb;
   logic          w_box_valid, w_frame_done;
   logic [XW-1:0] w_box_x1, w_box_x2;
   logic [YW-1:0] w_box_y1, w_box_y2;
   logic [CW-1:0] w_motion_count;

   // sof pins the current pixel to (0,0) so a misaligned stream resynchronises
   assign w_px = bus.in_sof ? '0 : r_x;
   assign w_py = bus.in_sof ? '0 : r_y;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x <= '0;
         r_y <= '0;
      end else if (bus.in_valid) begin
         if (w_px == X_LAST) begin
            r_x <= '0;
            r_y <= (w_py == Y_LAST) ? '0 : w_py + YW'(1);
         end else begin
            r_x <= w_px + XW'(1);
            r_y <= w_py;
         end
      end
   end

   assign w_abs = (r_s1_cur >= r_s1_bg) ? (r_s1_cur - r_s1_bg) : (r_s1_bg - r_s1_cur);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_sof    <= 1'b0;
         r_s1_x      <= '0;
         r_s1_y      <= '0;
         r_s1_cur    <= '0;
         r_s1_bg     <= '0;
         r_s1_thr    <= '0;
         r_s1_gray   <= '0;
         r_s1_minc   <= '0;
         r_s1_color  <= COLOR_BLACK;
         r_s2_valid  <= 1'b0;
         r_s2_sof    <= 1'b0;
         r_s2_motion <= 1'b0;
         r_s2_x      <= '0;
         r_s2_y      <= '0;
         r_s2_gray   <= '0;
         r_s2_minc   <= '0;
         r_s2_color  <= COLOR_BLACK;
         r_out_valid <= 1'b0;
         r_out_sof   <= 1'b0;
         r_out_rgb   <= COLOR_BLACK;
      end else begin
         r_s1_valid  <= bus.in_valid;
         r_s1_sof    <= bus.in_valid & bus.in_sof;
         r_s1_x      <= w_px;
         r_s1_y      <= w_py;
         r_s1_cur    <= bus.cur_value;
         r_s1_bg     <= bus.bg_value;
         r_s1_thr    <= bus.threshold;
         r_s1_gray   <= bus.gray;
         r_s1_minc   <= bus.min_count;
         r_s1_color  <= bus.box_color;
         r_s2_valid  <= r_s1_valid;
         r_s2_sof    <= r_s1_sof;
         r_s2_motion <= r_s1_valid && (w_abs > r_s1_thr);
         r_s2_x      <= r_s1_x;
         r_s2_y      <= r_s1_y;
         r_s2_gray   <= r_s1_gray;
         r_s2_minc   <= r_s1_minc;
         r_s2_color  <= r_s1_color;
         r_out_valid <= r_s2_valid;
         r_out_sof   <= r_s2_valid & r_s2_sof;
         r_out_rgb   <= w_rgb;
      end
   end

   motion_box_tracker #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .MARGIN(MARGIN)
   ) u_tracker (
      .clk           (clk),
      .rst           (rst),
      .i_valid       (r_s2_valid),
      .i_sof         (r_s2_sof),
      .i_x           (r_s2_x),
      .i_y           (r_s2_y),
      .i_motion      (r_s2_motion),
      .i_min_count   (r_s2_minc),
      .o_box_valid   (w_box_valid),
      .o_box_x1      (w_box_x1),
      .o_box_x2      (w_box_x2),
      .o_box_y1      (w_box_y1),
      .o_box_y2      (w_box_y2),
      .o_motion_count(w_motion_count),
      .o_frame_done  (w_frame_done)
   );

   if (GW >= 8) begin : g_gray_trunc
      assign w_gray8 = r_s2_gray[GW-1 -: 8];
   end else begin : g_gray_pad
      assign w_gray8 = {r_s2_gray, {(8 - GW){1'b0}}};
   end

   assign w_border = (int'(r_s2_x) < BORDER) || (int'(r_s2_x) >= IMG_W - BORDER) ||
                     (int'(r_s2_y) < BORDER) || (int'(r_s2_y) >= IMG_H - BORDER);

   // Box latched at the end of the previous frame; tracker updates after this pixel
   assign w_on_outline = w_box_valid &&
      ((((r_s2_y == w_box_y1) || (r_s2_y == w_box_y2)) &&
        (r_s2_x >= w_box_x1) && (r_s2_x <= w_box_x2)) ||
       (((r_s2_x == w_box_x1) || (r_s2_x == w_box_x2)) &&
        (r_s2_y > w_box_y1) && (r_s2_y < w_box_y2)));

   // Lowest priority first; later assignments override
   always_comb begin
      w_rgb = {w_gray8, w_gray8, w_gray8};
      if (w_on_outline) w_rgb = r_s2_color;
`ifdef MOTION_HIGHLIGHT_EN
      if (r_s2_motion) w_rgb = COLOR_RED;
`endif
      if (w_border || !r_s2_valid) w_rgb = COLOR_BLACK;
   end

   assign bus.out_valid    = r_out_valid;
   assign bus.out_sof      = r_out_sof;
   assign bus.out_rgb      = r_out_rgb;
   assign bus.box_valid    = w_box_valid;
   assign bus.box_x1       = w_box_x1;
   assign bus.box_x2       = w_box_x2;
   assign bus.box_y1       = w_box_y1;
   assign bus.box_y2       = w_box_y2;
   assign bus.motion_count = w_motion_count;
   assign bus.frame_done   = w_frame_done;

endmodule

// File: tb/tb_motion_box_overlay.sv
// Randomised bench for motion_box_overlay on a 16x12 frame; expected pixels and
// frame results come from a per-frame motion map scanned at the end of each frame.
module tb_motion_box_overlay;
   import image_process_pkg::*;

   localparam int W      = 16;
   localparam int H      = 12;
   localparam int DW     = 10;
   localparam int GW     = 8;
   localparam int MARGIN = 1;
   localparam int BORDER = 2;

   typedef struct packed {
      logic        v;
      logic        sof;
      logic [23:0] rgb;
      logic        fd;
      logic        bv;
      logic [3:0]  x1;
      logic [3:0]  x2;
      logic [3:0]  y1;
      logic [3:0]  y2;
      logic [7:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   motion_box_overlay_if #(.IMG_W(W), .IMG_H(H), .DW(DW), .GW(GW)) bus ();

   motion_box_overlay #(
      .IMG_W(W), .IMG_H(H), .DW(DW), .GW(GW), .MARGIN(MARGIN), .BORDER(BORDER)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   // reference state: next position, motion map of the frame in progress, latched result
   int         mx, my, fcnt;
   bit         mot[W*H];
   logic       m_bv;
   logic [3:0] m_x1, m_x2, m_y1, m_y2;
   logic [7:0] m_cnt;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void clear_frame();
      foreach (mot[i]) mot[i] = 1'b0;
      fcnt = 0;
   endfunction

   function automatic void model_reset();
      clear_frame();
      mx = 0; my = 0;
      m_bv = 1'b0; m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0; m_cnt = '0;
   endfunction

   function automatic void latch_frame(input int minc);
      int x1, x2, y1, y2;
      x1 = W - 1; x2 = 0; y1 = H - 1; y2 = 0;
      for (int y = MARGIN; y < H - MARGIN; y++)
         for (int x = MARGIN; x < W - MARGIN; x++)
            if (mot[y*W + x]) begin
               if (x < x1) x1 = x;
               if (x > x2) x2 = x;
               if (y < y1) y1 = y;
               if (y > y2) y2 = y;
            end
      m_x1 = x1[3:0]; m_x2 = x2[3:0]; m_y1 = y1[3:0]; m_y2 = y2[3:0];
      m_cnt = fcnt[7:0];
      m_bv  = (fcnt >= minc);
   endfunction

   function automatic logic [23:0] pixel_rgb(input int x, input int y, input bit m,
                                             input logic [7:0] g, input logic [23:0] col);
      if (x < BORDER || x >= W - BORDER || y < BORDER || y >= H - BORDER) return 24'h0;
`ifdef MOTION_HIGHLIGHT_EN
      if (m) return 24'hFF0000;
`endif
      if (m_bv && (((y == m_y1 || y == m_y2) && x >= m_x1 && x <= m_x2) ||
                   ((x == m_x1 || x == m_x2) && y > m_y1 && y < m_y2)))
         return col;
      return {g, g, g};
   endfunction

   // One clock: check the beat driven three cycles ago, then drive and model a new one
   task automatic step(input bit v, input bit sof, input int cur, input int bg, input int g,
                       input int thr, input int minc, input logic [23:0] col);
      exp_t e;
      int   px, py, d;
      bit   m;
      @(posedge clk);
      #1;
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         check_val("out_valid", bus.out_valid, e.v);
         check_val("out_sof", bus.out_sof, e.sof);
         check_val("out_rgb", bus.out_rgb, e.rgb);
         check_val("frame_done", bus.frame_done, e.fd);
         check_val("box_valid", bus.box_valid, e.bv);
         check_val("box_x1", bus.box_x1, e.x1);
         check_val("box_x2", bus.box_x2, e.x2);
         check_val("box_y1", bus.box_y1, e.y1);
         check_val("box_y2", bus.box_y2, e.y2);
         check_val("motion_count", bus.motion_count, e.cnt);
      end
      bus.in_valid  = v;
      bus.in_sof    = sof;
      bus.cur_value = cur[DW-1:0];
      bus.bg_value  = bg[DW-1:0];
      bus.gray      = g[GW-1:0];
      bus.threshold = thr[DW-1:0];
      bus.min_count = minc[7:0];
      bus.box_color = col;
      e = '0;
      if (v) begin
         px = sof ? 0 : mx;
         py = sof ? 0 : my;
         if (sof) clear_frame();
         d = (cur > bg) ? cur - bg : bg - cur;
         m = (d > thr);
         if (m) begin
            mot[py*W + px] = 1'b1;
            fcnt++;
         end
         e.v   = 1'b1;
         e.sof = sof;
         e.rgb = pixel_rgb(px, py, m, g[7:0], col);
         if (px == W - 1 && py == H - 1) begin
            latch_frame(minc);
            e.fd = 1'b1;
            clear_frame();
         end
         mx = (px == W - 1) ? 0 : px + 1;
         my = (px == W - 1) ? ((py == H - 1) ? 0 : py + 1) : py;
      end
      e.bv = m_bv; e.x1 = m_x1; e.x2 = m_x2; e.y1 = m_y1; e.y2 = m_y2; e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   // kind 0: static, 1: two motion pixels, 2: margin/threshold edges, 3: random
   task automatic run_frame(input int kind, input int minc, input int npix);
      int x, y, d, base, thr, g;
      logic [23:0] col;
      col = (kind == 3) ? 24'($urandom) : 24'h00FF00;
      for (int i = 0; i < npix; i++) begin
         x = i % W;
         y = i / W;
         thr = 70;
         d = 0;
         case (kind)
            1: if ((x == 5 && y == 4) || (x == 9 && y == 7)) d = 80;
            2: begin
               if ((x == 0 && y == 6) || (x == 6 && y == 6) || (x == 8 && y == 9)) d = 80;
               if (x == 3 && y == 3) d = 70;
            end
            3: begin
               thr = $urandom_range(60, 80);
               if ($urandom_range(0, 9) == 0) d = $urandom_range(55, 95);
               if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, 0, 0, 0, thr, minc, col);
            end
            default: d = 0;
         endcase
         base = $urandom_range(0, 1023 - d);
         g    = $urandom_range(0, 255);
         if ($urandom_range(0, 1) == 1) step(1'b1, i == 0, base + d, base, g, thr, minc, col);
         else                           step(1'b1, i == 0, base, base + d, g, thr, minc, col);
      end
   endtask

   task automatic check_cleared(input string tag);
      check_val({tag, "_out_valid"}, bus.out_valid, 0);
      check_val({tag, "_out_rgb"}, bus.out_rgb, 0);
      check_val({tag, "_box_valid"}, bus.box_valid, 0);
      check_val({tag, "_box_x2"}, bus.box_x2, 0);
      check_val({tag, "_motion_count"}, bus.motion_count, 0);
      check_val({tag, "_frame_done"}, bus.frame_done, 0);
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      #2;
      check_cleared("midrst");
      exp_q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.cur_value = '0; bus.bg_value = '0;
      bus.gray = '0; bus.threshold = '0; bus.min_count = '0; bus.box_color = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      rst = 1'b1;

      run_frame(0, 2, W*H);      // static scene
      run_frame(1, 2, W*H);      // box (5,9,4,7), count 2
      run_frame(0, 2, W*H);      // outline drawn
      run_frame(2, 2, W*H);      // margin pixel counted, abs==thr ignored
      run_frame(1, 3, W*H);      // min_count above count
      run_frame(0, 2, W*H);      // no outline
      run_frame(1, 2, 100);      // truncated by next sof
      run_frame(3, 2, W*H);
      run_frame(3, 4, 70);
      mid_reset();
      run_frame(0, 2, W*H);
      for (int f = 0; f < 5; f++) run_frame(3, $urandom_range(0, 25), W*H);
      repeat (4) step(1'b0, 1'b0, 0, 0, 0, 70, 2, 24'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/motion_box_overlay.md
# motion_box_overlay

Parametrised successor to the single-resolution motion-threshold stage in the image_process pipeline. Takes a per-pixel stream of current block-average values, matching background values and the original gray pixel, and computes the absolute difference against a runtime threshold. It tracks a per-frame motion bounding box and produces an RGB overlay stream: a box outline, optional motion highlighting and a blanked border. It sits between the block-average/background store and the video output formatter.

## Interface
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- DW, 10, width of block-average and background values
- GW, 8, gray pixel width
- MARGIN, 5, pixels/lines at each edge excluded from box tracking
- BORDER, 10, pixels/lines at each edge forced to black on output
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input pixel qualifier; no backpressure
- in_sof  in  1  with in_valid, marks pixel (0,0) of a frame
- cur_value  in  DW  current block-average value
- bg_value  in  DW  background block value for the same position
- gray  in  GW  original gray pixel
- threshold  in  DW  motion threshold, sampled per pixel
- min_count  in  CW  minimum motion pixels for the box to be valid; CW = $clog2(IMG_W*IMG_H+1)
- box_color  in  24  outline colour {R,G,B}
- out_valid  out  1  output pixel qualifier
- out_sof  out  1  in_sof delayed with the data
- out_rgb  out  24  overlay pixel {R,G,B}
- box_valid  out  1  the latched box is in use
- box_x1, box_x2  out  $clog2(IMG_W)  latched box columns
- box_y1, box_y2  out  $clog2(IMG_H)  latched box lines
- motion_count  out  CW  motion pixels in the last completed frame
- frame_done  out  1  one-cycle pulse when box and count are latched

## Operation
- Position counters x, y advance on in_valid. x wraps at IMG_W-1, and y increments on that wrap. y wraps at IMG_H-1.
- in_valid && in_sof forces (x,y) = (0,0) for that pixel, which resynchronises a misaligned stream.
- Stage 1 registers cur, bg, gray, x, y and sof.
- Stage 2 computes abs = |cur-bg| in DW bits (larger minus smaller, no overflow) and sets motion = abs > threshold (strict).
- Working box (x1n, x2n, y1n, y2n) is updated on a stage-2 motion pixel only when MARGIN <= x < IMG_W-MARGIN and MARGIN <= y < IMG_H-MARGIN. Update rule: x1n = min, x2n = max, y1n = min, y2n = max.
- Working count: motion pixels, saturating at all-ones.
- At stage-2 pixel (IMG_W-1, IMG_H-1):
  - latch box_*, set motion_count = count, set box_valid = (count >= min_count), pulse frame_done.
  - reinitialise working box to x1n = IMG_W-1, x2n = 0, y1n = IMG_H-1, y2n = 0, and count to 0.
  - The final pixel's contribution is included before the latch.
- A stage-2 pixel with sof reinitialises the working box and count without latching, which discards a truncated frame.
- Stage 3 output priority (highest first):
  - border: x < BORDER or x >= IMG_W-BORDER or y < BORDER or y >= IMG_H-BORDER gives 0.
  - highlight: motion gives {8'hFF,0,0} (see Configuration).
  - outline: box_valid and pixel on the outline of the latched box (top/bottom edge on y1/y2 with x1 <= x <= x2; left/right edge on x1/x2 with y1 < y < y2) gives box_color.
  - otherwise {gray,gray,gray}, with GW scaled to 8 bits by MSB truncation or zero-LSB padding.
- The box drawn in frame N is the box latched at the end of frame N-1.

## Timing
- Latency is exactly 3 clk from in_valid to out_valid for the same pixel. out_sof is aligned with that pixel.
- No stall: every cycle shifts the pipeline, and invalid beats propagate as out_valid = 0.
- frame_done is asserted in the cycle after the last pixel leaves stage 2, together with the updated box_*, box_valid and motion_count.
- Reset (asynchronous, any time, including mid-frame) clears all outputs to 0, counters to (0,0), working box to its init values and box_valid to 0. The first frame after reset therefore shows no outline.
- threshold, min_count and box_color may change at any cycle and take effect on the next pixel that samples them.

## Configuration
- MOTION_HIGHLIGHT_EN defined: motion pixels outside the border render red, as above.
- MOTION_HIGHLIGHT_EN undefined: the highlight priority level is removed. Motion pixels render as outline or gray; tracking and count are unchanged.

## Structure
- Shared package image_process_pkg: rgb_t (24-bit packed struct), the colour constants (COLOR_BLACK, COLOR_RED), and a function for clog2-based coordinate widths.
- One sub-module, motion_box_tracker: the working box, count, latch and frame_done logic, instantiated once. The pipeline and overlay mux stay in the top level.

## Test plan
- Static scene (cur = bg everywhere, IMG_W=16, IMG_H=12, BORDER=2, MARGIN=1) -> out_rgb = gray inside the border, 0 on the border, box_valid = 0, motion_count = 0.
- Frame 1 with abs = 80 > threshold 70 at pixels (5,4) and (9,7), min_count = 2 -> frame_done, box = (5,9,4,7), motion_count = 2. Frame 2 shows box_color on the outline only, with latency 3.
- Motion pixel at x = 0 (inside MARGIN) -> excluded from the box but counted in motion_count, and rendered black by BORDER.
- abs = threshold exactly -> no motion. min_count above the count -> box_valid = 0 and no outline.
- in_sof asserted mid-frame -> counters reset and no frame_done for the truncated frame. Reset asserted mid-frame -> all outputs 0 immediately, then recovery on the next sof.
- Bench built with and without MOTION_HIGHLIGHT_EN -> motion pixels render 24'hFF0000 and gray/outline respectively.
